// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first.
// A negative difference is turned into its magnitude by a second 10's-complement pass.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                m,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic [4*DIGITS-1:0] res,
  output logic                cout,
  output logic                neg,
  output logic                err,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [2:0] {IDLE, CHK, ADD, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic           m_q, m_d, carry_q, carry_d;
  logic [4:0]     idx_q, idx_d;
  logic           cout_q, cout_d, neg_q, neg_d, err_q, err_d;
  logic           busy_q, busy_d, done_q, done_d;

  logic [3:0]     op_x, op_y, sum_dig;
  logic [4:0]     sum_raw, sum_fix;
  logic           sum_c, last_digit;
  logic [W-1:0]   res_shift;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    has_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
  endfunction

  // One shared decimal digit adder; FIX feeds it the 9's complement of the result digit.
  always_comb begin
    op_x = a_q[3:0];
    op_y = m_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    if (state_q == FIX) begin
      op_x = 4'd9 - res_q[3:0];
      op_y = 4'd0;
    end
    sum_raw   = {1'b0, op_x} + {1'b0, op_y} + {4'b0, carry_q};
    sum_fix   = sum_raw + 5'd6;
    sum_c     = (sum_raw > 5'd9);
    sum_dig   = sum_c ? sum_fix[3:0] : sum_raw[3:0];
    res_shift = (res_q >> 4) | (W'(sum_dig) << (W - 4));
    last_digit = (idx_q == 5'(DIGITS - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          m_d     = m;
          state_d = CHK;
        end
      end
      CHK: begin
        res_d  = '0;
        cout_d = 1'b0;
        neg_d  = 1'b0;
        if (has_bad_digit(a_q) || has_bad_digit(b_q)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          err_d   = 1'b0;
          idx_d   = '0;
          carry_d = m_q;
          state_d = ADD;
        end
      end
      ADD: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        res_d   = res_shift;
        carry_d = sum_c;
        idx_d   = idx_q + 5'd1;
        if (last_digit) begin
          if (!m_q) begin
            cout_d  = sum_c;
            state_d = DONE;
          end else if (sum_c) begin
            neg_d   = 1'b0;
            state_d = DONE;
          end else begin
            neg_d   = 1'b1;
            idx_d   = '0;
            carry_d = 1'b1;
            state_d = FIX;
          end
        end
      end
      FIX: begin
        res_d   = res_shift;
        carry_d = sum_c;
        idx_d   = idx_q + 5'd1;
        if (last_digit) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign res       = res_q;
  assign cout      = cout_q;
  assign neg       = neg_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
